// File: rtl/input_pkg.sv
// Shared types and constants for the user-input conditioner.
// Holds the step FSM encoding, default timing and a fast simulation parameter set.
package input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  localparam int TICK_DIV_DEF    = 500000;
  localparam int DEB_SAMPLES_DEF = 4;

  localparam int SIM_TICK_DIV     = 4;
  localparam int SIM_DEB_SAMPLES  = 3;
  localparam int SIM_HOLD_TICKS   = 5;
  localparam int SIM_REPEAT_TICKS = 2;

  // Tick counter width: clog2 of the larger limit, never narrower than 1 bit.
  function automatic int cnt_width(input int hold_ticks, input int repeat_ticks);
    int m;
    m = (hold_ticks > repeat_ticks) ? hold_ticks : repeat_ticks;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-input conditioner: 2-FF synchronizer, tick-sampled history and debounced level.
// rise_nxt/fall_nxt flag the edge on which the level is about to move.
module debounce_bit #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic rise_nxt,
  output logic fall_nxt
);

  logic [1:0]             sync_r;
  logic [DEB_SAMPLES-1:0] hist_r;
  logic [DEB_SAMPLES-1:0] hist_nxt_s;
  logic                   level_r;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], din};
    end
  end

  // Level changes only when the whole shifted history agrees on the opposite value.
  always_comb begin
    hist_nxt_s = {hist_r[DEB_SAMPLES-2:0], sync_r[1]};
    if (tick) begin
      rise_nxt = (&hist_nxt_s) & ~level_r;
      fall_nxt = ~(|hist_nxt_s) & level_r;
    end else begin
      rise_nxt = 1'b0;
      fall_nxt = 1'b0;
    end
  end

  // History shift and debounced level, advanced only on the sample tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_r  <= '0;
      level_r <= 1'b0;
    end else if (tick) begin
      hist_r <= hist_nxt_s;
      if (rise_nxt) begin
        level_r <= 1'b1;
      end else if (fall_nxt) begin
        level_r <= 1'b0;
      end else begin
        level_r <= level_r;
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/input_conditioner.sv
// Switch/button front end: shared sample prescaler, per-input debouncers, edge pulses
// and an auto-repeat step generator on one button.
module input_conditioner
  import input_pkg::*;
#(
  parameter int N_SW         = 16,
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int DEB_SAMPLES  = DEB_SAMPLES_DEF,
  parameter int REP_IDX      = 0,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 40
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SW-1:0]  sw_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_SW-1:0]  sw_o,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic             sw_change_o,
  output logic             step_o,
  output logic             tick_o
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = cnt_width(HOLD_TICKS, REPEAT_TICKS);

  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  logic [N_SW-1:0]  sw_rise_s, sw_fall_s;
  logic [N_BTN-1:0] btn_rise_s, btn_fall_s;
  logic [N_BTN-1:0] btn_press_r, btn_release_r;
  logic             sw_change_r;
  step_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             step_r;

  assign tick_s = (div_r == DIV_W'(TICK_DIV - 1));

  // Sample-tick prescaler, wraps at TICK_DIV-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .clk      (clk),
      .rstn     (rstn),
      .din      (sw_i[i]),
      .tick     (tick_s),
      .level    (sw_o[i]),
      .rise_nxt (sw_rise_s[i]),
      .fall_nxt (sw_fall_s[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .clk      (clk),
      .rstn     (rstn),
      .din      (btn_i[i]),
      .tick     (tick_s),
      .level    (btn_o[i]),
      .rise_nxt (btn_rise_s[i]),
      .fall_nxt (btn_fall_s[i])
    );
  end

  // Edge pulses, registered on the same edge on which the debounced level moves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_press_r   <= '0;
      btn_release_r <= '0;
      sw_change_r   <= 1'b0;
    end else begin
      btn_press_r   <= btn_rise_s;
      btn_release_r <= btn_fall_s;
      sw_change_r   <= |(sw_rise_s | sw_fall_s);
    end
  end

  // Step generator: release is checked first so it beats a step due on the same tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      step_r  <= 1'b0;
    end else begin
      step_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (btn_rise_s[REP_IDX]) begin
            step_r  <= 1'b1;
            cnt_r   <= '0;
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (btn_fall_s[REP_IDX]) begin
            state_r <= ST_IDLE;
          end else if (tick_s) begin
            if (cnt_r == CNT_W'(HOLD_TICKS - 1)) begin
              step_r  <= 1'b1;
              cnt_r   <= '0;
              state_r <= ST_REPEAT;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (btn_fall_s[REP_IDX]) begin
            state_r <= ST_IDLE;
          end else if (tick_s) begin
            if (cnt_r == CNT_W'(REPEAT_TICKS - 1)) begin
              step_r <= 1'b1;
              cnt_r  <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign btn_press_o   = btn_press_r;
  assign btn_release_o = btn_release_r;
  assign sw_change_o   = sw_change_r;
  assign step_o        = step_r;
  assign tick_o        = tick_s;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized bench for input_conditioner against a sample-run-length reference model
// and a tick-count formula for the auto-repeat step schedule.
module tb_input_conditioner;
  import input_pkg::*;

  localparam int N_SW  = 16;
  localparam int N_BTN = 5;
  localparam int NI    = N_SW + N_BTN;
  localparam int TD    = SIM_TICK_DIV;
  localparam int S     = SIM_DEB_SAMPLES;
  localparam int HT    = SIM_HOLD_TICKS;
  localparam int RT    = SIM_REPEAT_TICKS;
  localparam int REP   = 0;

  logic             clk   = 1'b0;
  logic             rstn  = 1'b1;
  logic [N_SW-1:0]  sw_i  = '0;
  logic [N_BTN-1:0] btn_i = '0;
  logic [N_SW-1:0]  sw_o;
  logic [N_BTN-1:0] btn_o, btn_press_o, btn_release_o;
  logic             sw_change_o, step_o, tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_SW(N_SW), .N_BTN(N_BTN), .TICK_DIV(TD), .DEB_SAMPLES(S),
    .REP_IDX(REP), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rstn(rstn), .sw_i(sw_i), .btn_i(btn_i),
    .sw_o(sw_o), .btn_o(btn_o), .btn_press_o(btn_press_o),
    .btn_release_o(btn_release_o), .sw_change_o(sw_change_o),
    .step_o(step_o), .tick_o(tick_o)
  );

  // Reference model: inputs reach the sampler two edges late; a level follows once the
  // last S tick samples agree; steps at k = 0, HT, HT+RT, ... ticks after the press.
  logic [NI-1:0] din_q[$];
  logic [NI-1:0] m_level, m_rise, m_fall, m_old, m_smp, run_val;
  int            run_len [NI];
  int            m_edges, m_k;
  logic          m_active, m_step, m_swchg, m_tick;
  bit            m_fresh = 1'b1;

  initial begin
    forever begin
      if (!rstn || m_fresh) begin
        m_fresh = 1'b0;
        din_q.delete();
        din_q.push_back('0);
        din_q.push_back('0);
        m_level = '0; m_rise = '0; m_fall = '0; run_val = '0;
        for (int i = 0; i < NI; i++) run_len[i] = S;
        m_edges = 0; m_k = 0; m_active = 1'b0;
        m_step = 1'b0; m_swchg = 1'b0; m_tick = 1'b0;
      end else begin
        m_edges++;
        din_q.push_back({btn_i, sw_i});
        m_smp  = din_q.pop_front();
        m_rise = '0; m_fall = '0; m_step = 1'b0;
        if (m_edges % TD == 0) begin
          m_old = m_level;
          for (int i = 0; i < NI; i++) begin
            if (m_smp[i] == run_val[i]) begin
              if (run_len[i] < S) run_len[i]++;
            end else begin
              run_val[i] = m_smp[i];
              run_len[i] = 1;
            end
            if (run_len[i] >= S) m_level[i] = run_val[i];
          end
          m_rise = m_level & ~m_old;
          m_fall = m_old & ~m_level;
          if (m_rise[N_SW+REP]) begin
            m_step = 1'b1; m_active = 1'b1; m_k = 0;
          end else if (m_active) begin
            if (m_fall[N_SW+REP]) begin
              m_active = 1'b0;
            end else begin
              m_k++;
              m_step = (m_k == HT) || (m_k > HT && (m_k - HT) % RT == 0);
            end
          end
        end
        m_swchg = |(m_rise[N_SW-1:0] | m_fall[N_SW-1:0]);
        m_tick  = (m_edges % TD == TD - 1);
      end
      @(posedge clk or negedge rstn);
    end
  end

  logic [33:0] obs, exp_v;
  assign obs   = {sw_o, btn_o, btn_press_o, btn_release_o, sw_change_o, step_o, tick_o};
  assign exp_v = {m_level[N_SW-1:0], m_level[NI-1:N_SW], m_rise[NI-1:N_SW],
                  m_fall[NI-1:N_SW], m_swchg, m_step, m_tick};

  task automatic test_reset();
    int first_tick, chg_cnt, chg_cyc;
    first_tick = -1; chg_cnt = 0; chg_cyc = -1;
    sw_i = 16'hFFFF; btn_i = '0;
    #2 rstn = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, expected 0", obs); end
    end
    rstn = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_model cyc %0d: got %h, expected %h", c, obs, exp_v); end
      if (tick_o && first_tick < 0) first_tick = c;
      if (sw_change_o) begin chg_cnt++; chg_cyc = c; end
    end
    n_checks++;
    if (first_tick != 3) begin n_fail++; $display("FAIL reset_first_tick: got %0d, expected 3", first_tick); end
    n_checks++;
    if (chg_cnt != 1 || chg_cyc != 12) begin
      n_fail++; $display("FAIL reset_sw_change: got %0d pulses at cyc %0d, expected 1 at 12", chg_cnt, chg_cyc);
    end
    n_checks++;
    if (sw_o !== 16'hFFFF) begin n_fail++; $display("FAIL reset_sw_level: got %h, expected ffff", sw_o); end
  endtask

  task automatic test_glitch();
    int len, off, b;
    logic g;
    for (int n = 0; n < 4; n++) begin
      len = $urandom_range(1, (S - 1) * TD);
      off = $urandom_range(0, TD - 1);
      b   = $urandom_range(0, N_SW - 1);
      for (int c = 0; c < off + len + S * TD + 4; c++) begin
        g = (c >= off && c < off + len) ? 1'b1 : 1'b0;
        btn_i[1] = g;
        sw_i[b]  = ~g;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL glitch_model len %0d: got %h, expected %h", len, obs, exp_v); end
        n_checks++;
        if ({btn_o[1], btn_press_o[1], btn_release_o[1]} !== 3'b000 || sw_o !== 16'hFFFF) begin
          n_fail++; $display("FAIL glitch_outputs len %0d: got btn %b sw %h, expected quiet", len, btn_o, sw_o);
        end
      end
    end
  endtask

  task automatic test_switches();
    logic [N_SW-1:0] pat, prev;
    int hold, chg;
    prev = sw_i;
    for (int t = 0; t < 6; t++) begin
      pat  = (t == 0) ? ~prev : 16'($urandom);
      hold = $urandom_range((S + 1) * TD, (S + 3) * TD);
      chg  = 0;
      sw_i = pat;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL switch_model: got %h, expected %h", obs, exp_v); end
        if (sw_change_o) chg++;
      end
      n_checks++;
      if (sw_o !== pat) begin n_fail++; $display("FAIL switch_level: got %h, expected %h", sw_o, pat); end
      n_checks++;
      if (chg != ((pat != prev) ? 1 : 0)) begin
        n_fail++; $display("FAIL switch_change_count: got %0d, expected %0d", chg, (pat != prev) ? 1 : 0);
      end
      prev = pat;
    end
  endtask

  task automatic test_press_release();
    int n_press, n_rel, c_press, c_rel;
    n_press = 0; n_rel = 0; c_press = -1; c_rel = -1;
    for (int ph = 0; ph < 2; ph++) begin
      btn_i[2] = (ph == 0) ? 1'b1 : 1'b0;
      for (int c = 1; c <= 20 * TD; c++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL press_model cyc %0d: got %h, expected %h", c, obs, exp_v); end
        if (btn_press_o[2])   begin n_press++; c_press = c; end
        if (btn_release_o[2]) begin n_rel++;   c_rel   = c; end
      end
    end
    n_checks++;
    if (n_press != 1 || n_rel != 1) begin
      n_fail++; $display("FAIL press_counts: got %0d/%0d, expected 1/1", n_press, n_rel);
    end
    n_checks++;
    if (c_press < 2 * TD + 3 || c_press > 3 * TD + 2) begin
      n_fail++; $display("FAIL press_latency: got %0d, expected %0d..%0d", c_press, 2 * TD + 3, 3 * TD + 2);
    end
    n_checks++;
    if (c_rel < 2 * TD + 3 || c_rel > 3 * TD + 2) begin
      n_fail++; $display("FAIL release_latency: got %0d, expected %0d..%0d", c_rel, 2 * TD + 3, 3 * TD + 2);
    end
  endtask

  task automatic test_auto_repeat();
    int p, steps[$];
    int exp_steps[5];
    exp_steps = '{0, HT, HT + RT, HT + 2 * RT, HT + 3 * RT};
    p = -1;
    btn_i[0] = 1'b1;
    for (int c = 1; c <= 24 * TD; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL repeat_model cyc %0d: got %h, expected %h", c, obs, exp_v); end
      if (btn_press_o[0] && p < 0) p = c;
      if (step_o) steps.push_back((p < 0 || (c - p) % TD != 0) ? -1 : (c - p) / TD);
      if (p >= 0 && c == p + 9 * TD) btn_i[0] = 1'b0;
    end
    btn_i[0] = 1'b0;
    n_checks++;
    if (p < 0) begin n_fail++; $display("FAIL repeat_press: got none within %0d cycles, expected a press", 24 * TD); end
    n_checks++;
    if (steps.size() != 5) begin n_fail++; $display("FAIL repeat_step_count: got %0d, expected 5", steps.size()); end
    for (int i = 0; i < 5 && i < steps.size(); i++) begin
      n_checks++;
      if (steps[i] != exp_steps[i]) begin
        n_fail++; $display("FAIL repeat_step_%0d: got tick %0d, expected %0d", i, steps[i], exp_steps[i]);
      end
    end
  endtask

  task automatic test_release_race();
    int p, f, c_rel, steps[$], exp_q[$];
    f = 7 + 2 * int'($urandom_range(0, 3));
    exp_q.push_back(0);
    for (int k = HT; k < f; k += RT) exp_q.push_back(k);
    p = -1; c_rel = -1;
    btn_i[0] = 1'b1;
    for (int c = 1; c <= 24 * TD; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL race_model cyc %0d: got %h, expected %h", c, obs, exp_v); end
      if (btn_press_o[0] && p < 0) p = c;
      if (step_o) steps.push_back((p < 0 || (c - p) % TD != 0) ? -1 : (c - p) / TD);
      if (btn_release_o[0]) begin
        c_rel = c;
        n_checks++;
        if (dut.state_r !== ST_IDLE) begin n_fail++; $display("FAIL race_state_at_release: got %0d, expected IDLE", dut.state_r); end
      end
      if (p >= 0 && c == p + (f - 3) * TD) btn_i[0] = 1'b0;
    end
    n_checks++;
    if (p < 0 || c_rel != p + f * TD) begin
      n_fail++; $display("FAIL race_release_time: got cyc %0d, expected %0d", c_rel, p + f * TD);
    end
    n_checks++;
    if (steps != exp_q) begin
      n_fail++; $display("FAIL race_steps: got %0d steps (last %0d), expected %0d (last %0d)",
                         steps.size(), (steps.size() > 0) ? steps[$] : -1, exp_q.size(), exp_q[$]);
    end
  endtask

  task automatic test_reset_mid();
    int p, n_step, n_press;
    bit done;
    p = -1; done = 1'b0; n_step = 0; n_press = 0;
    btn_i[0] = 1'b1;
    for (int c = 1; c <= 20 * TD && !done; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL midreset_model cyc %0d: got %h, expected %h", c, obs, exp_v); end
      if (btn_press_o[0] && p < 0) p = c;
      if (p >= 0 && c == p + (HT + 1) * TD) done = 1'b1;
    end
    n_checks++;
    if (!done || dut.state_r !== ST_REPEAT) begin
      n_fail++; $display("FAIL midreset_in_repeat: got state %0d, expected REPEAT", dut.state_r);
    end
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (obs !== '0 || dut.state_r !== ST_IDLE) begin
        n_fail++; $display("FAIL midreset_outputs: got %h state %0d, expected 0 and IDLE", obs, dut.state_r);
      end
    end
    rstn = 1'b1;
    for (int c = 1; c <= 5 * TD; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL midreset_after cyc %0d: got %h, expected %h", c, obs, exp_v); end
      if (btn_press_o[0]) n_press++;
      if (step_o) begin
        n_step++;
        n_checks++;
        if (!btn_press_o[0]) begin n_fail++; $display("FAIL midreset_stray_step cyc %0d: got step, expected none", c); end
      end
    end
    n_checks++;
    if (n_step != 1 || n_press != 1) begin
      n_fail++; $display("FAIL midreset_repress: got %0d steps %0d presses, expected 1 and 1", n_step, n_press);
    end
    btn_i[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_switches();
    test_press_release();
    test_auto_repeat();
    test_release_race();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
